// File: rtl/rsa_pkg.sv
// Shared RSA datapath constants and the exponent bit-stream FSM encoding.
package rsa_pkg;

   localparam int RSA_WIDTH    = 1024;
   localparam int RSA_WORD_W   = 32;
   localparam int RSA_NUMBIT_W = 11;
   localparam int RSA_IDX_W    = 10;
   localparam int RSA_WSEL_W   = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_FETCH,
      ST_SHIFT,
      ST_FIN
   } bs_state_e;

endpackage

// File: rtl/rsa_word_sel.sv
// Combinational 32:1 word mux over the 1024-bit exponent; word k is e_i[32k+31:32k].
module rsa_word_sel
   import rsa_pkg::*;
(
   input  logic [RSA_WIDTH-1:0]  e_i,
   input  logic [RSA_WSEL_W-1:0] sel_i,
   output logic [RSA_WORD_W-1:0] word_o
);

   assign word_o = e_i[{sel_i, 5'd0} +: RSA_WORD_W];

endmodule

// File: rtl/rsa_exp_bit_stream.sv
// Streams exponent bits MSB-first from bit N-1 down to 0, one per handshake,
// refilling a 32-bit shift register one word at a time.
module rsa_exp_bit_stream
   import rsa_pkg::*;
(
   input  logic                    iClk,
   input  logic                    iRst,
   input  logic                    iStart,
   input  logic [RSA_WIDTH-1:0]    iE,
   input  logic [RSA_NUMBIT_W-1:0] iNumBit,
   output logic                    oBit,
   output logic                    oBitValid,
   input  logic                    iBitReady,
   output logic                    oLast,
   output logic                    oBusy,
   output logic                    oDone
);

   bs_state_e             state_q, state_d;
   logic [RSA_IDX_W-1:0]  idx_q, idx_d;
   logic [RSA_WORD_W-1:0] wreg_q, wreg_d;

   logic [RSA_NUMBIT_W-1:0] num_clamped;
   logic [RSA_IDX_W-1:0]    idx_init;
   logic [RSA_WORD_W-1:0]   fetch_word;

   assign num_clamped = (iNumBit > 11'd1024) ? 11'd1024 : iNumBit;
   // N=1024 has low bits 0, so the 10-bit subtraction wraps to 1023 as required.
   assign idx_init    = num_clamped[RSA_IDX_W-1:0] - 10'd1;

   rsa_word_sel u_word_sel (
      .e_i    (iE),
      .sel_i  (idx_q[9:5]),
      .word_o (fetch_word)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      wreg_d  = wreg_q;
      case (state_q)
         ST_IDLE: begin
            if (iStart) begin
               if (num_clamped == '0) begin
                  state_d = ST_FIN;
               end else begin
                  idx_d   = idx_init;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FETCH: begin
            // Left-align so exponent bit idx sits at wreg[31].
            wreg_d  = fetch_word << (5'd31 - idx_q[4:0]);
            state_d = ST_SHIFT;
         end
         ST_SHIFT: begin
            if (iBitReady) begin
               if (idx_q == '0) begin
                  state_d = ST_FIN;
               end else if (idx_q[4:0] == 5'd0) begin
                  idx_d   = idx_q - 10'd1;
                  state_d = ST_FETCH;
               end else begin
                  wreg_d  = wreg_q << 1;
                  idx_d   = idx_q - 10'd1;
               end
            end
         end
         ST_FIN: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         wreg_q  <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         wreg_q  <= wreg_d;
      end
   end

   assign oBitValid = (state_q == ST_SHIFT);
   assign oBit      = oBitValid & wreg_q[RSA_WORD_W-1];
   assign oLast     = oBitValid & (idx_q == '0);
   assign oBusy     = (state_q != ST_IDLE);
   assign oDone     = (state_q == ST_FIN);

endmodule
